i2c_target_regfile: RTL and testbench

Parametrised I2C target (slave) with an internal byte-wide register file. It sits between the open-drain SDA/SCL pad logic (SB_IO tristate in the top level) and fabric logic that consumes the registers. Compared with the single-purpose I2C example, it adds a configurable address, register count, synchronizer depth, pointer auto-increment with wrap, repeated-START support, fabric write strobes and a debug bus.

---
 rtl/i2c_target_regfile.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, pointer auto-increment,
// repeated-START support, fabric write strobes and a debug bus.
//
// Handshake note: wr_strobe_o is a valid-only pulse with no ready. It is high
// for exactly one clk, and wr_addr_o and regs_o already hold the new
// register contents in that cycle.
module i2c_target_regfile #(
    parameter logic [6:0] I2C_ADDR    = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i2c_scl_i,
    input  logic                  i2c_sda_i,
    output logic                  i2c_sda_o,
    output logic                  i2c_sda_oe,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_strobe_o,
    output logic [PW-1:0]         wr_addr_o,
    output logic [7:0]            debug_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WR        = 4'd5,
        S_WR_ACK    = 4'd6,
        S_RD        = 4'd7,
        S_RD_ACK    = 4'd8,
        S_WAIT_STOP = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   rnw_q, rnw_d;
    logic                   oe_q, oe_d;
    logic                   strobe_q, strobe_d;
    logic [PW-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];

    logic          scl_s, sda_s;
    logic          scl_rise, scl_fall, bus_start, bus_stop;
    logic [7:0]    byte_in;
    logic          last_bit, ptr_ok;
    logic [PW-1:0] ptr_inc;

    // Synchronizer shift and edge/condition detection on the synchronized pins
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda_i};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
        bus_start  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        bus_stop   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        byte_in    = {shift_q[6:0], sda_s};
        last_bit   = (bit_cnt_q == 3'd7);
        ptr_ok     = ({1'b0, byte_in} < 9'(NUM_REGS));
        ptr_inc    = ptr_q + PW'(1);
    end

    // Protocol FSM: START/STOP first, then per-state bit handling on SCL edges
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rnw_d     = rnw_q;
        oe_d      = oe_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        regs_d    = regs_q;
        if (bus_start) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
        end else if (bus_stop) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        if (byte_in[7:1] == I2C_ADDR) begin
                            state_d = S_ADDR_ACK;
                            rnw_d   = byte_in[0];
                            if (byte_in[0]) shift_d = regs_q[ptr_q];
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_PTR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        if (ptr_ok) begin
                            ptr_d   = byte_in[PW-1:0];
                            state_d = S_PTR_ACK;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_WR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        regs_d[ptr_q] = byte_in;
                        strobe_d      = 1'b1;
                        wr_addr_d     = ptr_q;
                        ptr_d         = ptr_inc;
                        state_d       = S_WR_ACK;
                    end
                end
                // First SCL fall drives the ACK, the second one releases it
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == S_ADDR_ACK && rnw_q) begin
                            state_d = S_RD;
                            oe_d    = ~shift_q[7];
                        end else if (state_q == S_ADDR_ACK) begin
                            state_d = S_PTR;
                        end else begin
                            state_d = S_WR;
                        end
                    end
                end
                // Bit 0 is already on the bus when RD is entered; a fall with
                // bit_cnt back at zero means all eight bits have been clocked
                S_RD: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            oe_d    = 1'b0;
                            state_d = S_RD_ACK;
                        end else begin
                            oe_d = ~shift_q[7];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            ptr_d   = ptr_inc;
                            shift_d = regs_q[ptr_inc];
                        end
                    end else if (scl_fall) begin
                        state_d   = S_RD;
                        bit_cnt_d = 3'd0;
                        oe_d      = ~shift_q[7];
                    end
                end
                S_IDLE, S_WAIT_STOP: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, datapath and register file flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            ptr_q      <= '0;
            rnw_q      <= 1'b0;
            oe_q       <= 1'b0;
            strobe_q   <= 1'b0;
            wr_addr_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'd0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rnw_q      <= rnw_d;
            oe_q       <= oe_d;
            strobe_q   <= strobe_d;
            wr_addr_q  <= wr_addr_d;
            regs_q     <= regs_d;
        end
    end

    // Flatten the register file for the fabric
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_o[8*i +: 8] = regs_q[i];
    end

    assign i2c_sda_o   = 1'b0;
    assign i2c_sda_oe  = oe_q;
    assign wr_strobe_o = strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign debug_o     = {state_q, bit_cnt_q, oe_q};

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, transaction-level
// register model, and queue-based monitors for write strobes and read data.
module tb_i2c_target_regfile;

    localparam int NR = 16;
    localparam int Q  = 5;   // clk cycles per quarter SCL period (SCL = clk/20)

    // ---------------- clock / reset / bus ----------------
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl   = 1'b1;
    logic          sda_m = 1'b1;   // master drive level, 1 = released
    logic          sda_pin;
    logic          sda_o, sda_oe, wr_strobe;
    logic [NR*8-1:0] regs_o;
    logic [3:0]    wr_addr;
    logic [7:0]    debug;

    always #5 clk = ~clk;

    assign sda_pin = sda_m & ~sda_oe;   // open-drain wired-AND

    i2c_target_regfile #(.I2C_ADDR(7'h42), .NUM_REGS(NR), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2c_scl_i   (scl),
        .i2c_sda_i   (sda_pin),
        .i2c_sda_o   (sda_o),
        .i2c_sda_oe  (sda_oe),
        .regs_o      (regs_o),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .debug_o     (debug)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_q[$];      // expected write strobes {addr, data}
    logic [7:0]  exp_rd_q[$];   // expected read bytes
    logic [7:0]  model_regs [NR];
    int          model_ptr;
    logic [7:0]  rd_byte;
    event        rd_done;
    int          oe_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Write-strobe monitor
    always @(negedge clk) begin
        if (rst_n && wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe_unexpected actual addr=%0d required=no strobe", wr_addr);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("strobe_addr_data", {wr_addr, regs_o[wr_addr*8 +: 8]}, 32'(e));
            end
        end
    end

    // Read-data monitor
    initial begin
        forever begin
            @(rd_done);
            if (exp_rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected actual=0x%0h required=no read", rd_byte);
            end else begin
                logic [7:0] e;
                e = exp_rd_q.pop_front();
                check("rd_data", 32'(rd_byte), 32'(e));
            end
        end
    end

    // Count cycles in which the target pulls SDA
    always @(negedge clk) if (sda_oe === 1'b1) oe_cycles <= oe_cycles + 1;

    // ---------------- master driver tasks ----------------
    task automatic qwait;
        repeat (Q) @(negedge clk);
    endtask

    // START from idle, or repeated START when SCL is low
    task automatic bus_start;
        sda_m = 1'b1; qwait;
        scl   = 1'b1; qwait;
        sda_m = 1'b0; qwait;
        scl   = 1'b0; qwait;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; qwait;
        scl   = 1'b1; qwait;
        sda_m = 1'b1; qwait;
        qwait;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    qwait;
        scl   = 1'b1; qwait; qwait;
        scl   = 1'b0; qwait;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qwait;
        scl   = 1'b1; qwait;
        b     = sda_pin; qwait;
        scl   = 1'b0; qwait;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
        rd_byte = d;
        -> rd_done;
    endtask

    // ---------------- transaction-level model + stimulus ----------------
    task automatic txn_write(input logic [7:0] addr, input logic [7:0] ptrb,
                             input int n, input logic [7:0] data [4]);
        logic ack;
        logic match, ok;
        match = (addr[7:1] == 7'h42) && !addr[0];
        ok    = match && (ptrb < 8'(NR));
        bus_start;
        write_byte(addr, ack);
        check("wr_addr_ack", 32'(ack), 32'(!match));
        write_byte(ptrb, ack);
        check("wr_ptr_ack", 32'(ack), 32'(!ok));
        if (ok) model_ptr = int'(ptrb);
        for (int i = 0; i < n; i++) begin
            if (ok) begin
                model_regs[model_ptr] = data[i];
                exp_q.push_back({4'(model_ptr), data[i]});
                model_ptr = (model_ptr + 1) % NR;
            end
            write_byte(data[i], ack);
            check("wr_data_ack", 32'(ack), 32'(!ok));
        end
        bus_stop;
        check("idle_after_wr", 32'(debug[7:4]), 32'd0);
    endtask

    task automatic txn_read(input logic [7:0] addr, input int n,
                            input logic set_ptr, input logic [7:0] ptrb);
        logic ack;
        logic match;
        logic [7:0] d;
        bus_start;
        if (set_ptr) begin
            write_byte(8'h84, ack);
            check("rd_setup_addr_ack", 32'(ack), 32'd0);
            write_byte(ptrb, ack);
            check("rd_setup_ptr_ack", 32'(ack), 32'(ptrb >= 8'(NR)));
            if (ptrb < 8'(NR)) model_ptr = int'(ptrb);
            bus_start;   // repeated START
        end
        match = (addr[7:1] == 7'h42) && addr[0];
        write_byte(addr, ack);
        check("rd_addr_ack", 32'(ack), 32'(!match));
        if (match) begin
            for (int i = 0; i < n; i++) begin
                exp_rd_q.push_back(model_regs[model_ptr]);
                read_byte(i == n - 1, d);
                if (i != n - 1) model_ptr = (model_ptr + 1) % NR;
            end
            check("oe_after_nack", 32'(sda_oe), 32'd0);
        end
        bus_stop;
        check("idle_after_rd", 32'(debug[7:4]), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] dat [4];
        logic       ack;
        int         oe_before;
        int         w;

        for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
        model_ptr = 0;

        // reset state
        repeat (5) @(negedge clk);
        check("rst_oe", 32'(sda_oe), 32'd0);
        check("rst_sda_o", 32'(sda_o), 32'd0);
        check("rst_regs_zero", 32'(regs_o == '0), 32'd1);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_debug", 32'(debug), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // write burst: reg3=AA, reg4=BB
        dat[0] = 8'hAA; dat[1] = 8'hBB; dat[2] = 8'h00; dat[3] = 8'h00;
        txn_write(8'h84, 8'h03, 2, dat);

        // pointer wrap: reg15=11, reg0=22
        dat[0] = 8'h11; dat[1] = 8'h22;
        txn_write(8'h84, 8'h0F, 2, dat);

        // repeated-START read of reg2..reg4
        txn_read(8'h85, 3, 1'b1, 8'h02);

        // wrong address: no ACK, WAIT_STOP, SDA never pulled
        oe_before = oe_cycles;
        bus_start;
        write_byte(8'h86, ack);
        check("wrong_addr_nack", 32'(ack), 32'd1);
        check("wrong_addr_state", 32'(debug[7:4]), 32'd9);
        write_byte(8'h01, ack);
        check("wrong_addr_ptr_nack", 32'(ack), 32'd1);
        bus_stop;
        check("wrong_addr_no_oe", 32'(oe_cycles - oe_before), 32'd0);
        check("wrong_addr_idle", 32'(debug[7:4]), 32'd0);

        // pointer unchanged by the wrong-address transfer
        txn_read(8'h85, 1, 1'b0, 8'h00);

        // bad pointer: NACKed, following data ignored
        dat[0] = 8'h55;
        txn_write(8'h84, 8'h10, 1, dat);
        txn_read(8'h85, 2, 1'b0, 8'h00);

        // randomized traffic
        for (int t = 0; t < 25; t++) begin
            int kind, n;
            logic [7:0] pb;
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            pb   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255))
                                               : 8'($urandom_range(0, NR - 1));
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            if (kind == 0)
                txn_write(($urandom_range(0, 5) == 0) ? 8'h86 : 8'h84, pb, n, dat);
            else if (kind == 1)
                txn_read(8'h85, n, 1'b1, pb);
            else
                txn_read(($urandom_range(0, 5) == 0) ? 8'h87 : 8'h85, n, 1'b0, 8'h00);
        end

        // final register file against the model
        repeat (5) @(negedge clk);
        for (int i = 0; i < NR; i++)
            check($sformatf("reg%0d", i), 32'(regs_o[8*i +: 8]), 32'(model_regs[i]));

        // reset during RD while the target pulls SDA
        dat[0] = 8'h0F;
        txn_write(8'h84, 8'h05, 1, dat);
        txn_write(8'h84, 8'h05, 0, dat);
        bus_start;
        write_byte(8'h85, ack);
        check("rstrd_addr_ack", 32'(ack), 32'd0);
        w = 0;
        while (sda_oe !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("rstrd_oe_asserted", 32'(sda_oe), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstrd_oe_released", 32'(sda_oe), 32'd0);
        check("rstrd_regs_zero", 32'(regs_o == '0), 32'd1);
        check("rstrd_debug", 32'(debug), 32'd0);
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        txn_read(8'h85, 1, 1'b0, 8'h00);

        repeat (10) @(negedge clk);
        check("strobes_pending", 32'(exp_q.size()), 32'd0);
        check("reads_pending", 32'(exp_rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
